// File: rtl/multicycle_core_if.sv
// Memory port bundle for multicycle_core.
//   master (core)  : drives req, we, addr, wdata; receives ready, rdata
//   slave (memory) : the mirror image
// A transfer completes on a rising clock edge with req=1 and ready=1.
interface multicycle_core_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
);
  logic              req;
  logic              we;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ready, rdata);
  modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/multicycle_core.sv
// Multicycle load/store CPU with an internal register file, add/sub datapath
// and one memory port using a req/ready handshake with arbitrary wait states.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   mem       memory port (master side of multicycle_core_if)
//   o_halted  high while in HALTED
//   o_dbg_pc  current program counter
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FETCH  | read instruction at PC into IR, PC+1
// S_DECODE | execute ALU/RST/HALT/NOP, or go fetch the operand word
// S_OPER   | read operand word at PC into OP, PC+1; finish LDI/JMP/BEQZ
// S_MEM    | data access at OP for LOAD/STORE
// S_HALTED | idle, left only through rst
module multicycle_core #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 15,
  parameter int                REG_W    = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h2400
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_core_if.master      mem,
  output logic                   o_halted,
  output logic [ADDR_W-1:0]      o_dbg_pc
);

  localparam int NREG = 2 ** REG_W;

  localparam logic [5:0] OP_RST   = 6'd0;
  localparam logic [5:0] OP_LOAD  = 6'd1;
  localparam logic [5:0] OP_STORE = 6'd2;
  localparam logic [5:0] OP_LDI   = 6'd3;
  localparam logic [5:0] OP_JMP   = 6'd4;
  localparam logic [5:0] OP_ADD   = 6'd5;
  localparam logic [5:0] OP_SUB   = 6'd6;
  localparam logic [5:0] OP_BEQZ  = 6'd7;
  localparam logic [5:0] OP_HALT  = 6'd8;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_OPER, S_MEM, S_HALTED} state_t;

  state_t            r_state, w_next_state;
  logic [ADDR_W-1:0] r_pc, w_pc_next, w_pc_inc;
  logic [DATA_W-1:0] r_ir;
  // only the address part of the operand word is ever consumed after OPER
  logic [ADDR_W-1:0] r_op;
  logic [DATA_W-1:0] r_regs [NREG];

  logic              w_ir_we, w_op_we, w_reg_we;
  logic [DATA_W-1:0] w_reg_wdata;
  logic              w_req, w_we;
  logic [ADDR_W-1:0] w_addr;

  logic [5:0]        w_opcode;
  logic [REG_W-1:0]  w_rd, w_rs;
  logic [DATA_W-1:0] w_rd_val, w_rs_val;

  assign w_opcode = r_ir[5:0];
  assign w_rd     = r_ir[6 +: REG_W];
  assign w_rs     = r_ir[6+REG_W +: REG_W];
  assign w_rd_val = r_regs[w_rd];
  assign w_rs_val = r_regs[w_rs];
  assign w_pc_inc = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next_state;
  end

  // Handshake states keep req high until ready; all updates are gated on
  // mem.ready so a wait state simply repeats the same cycle.
  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_ir_we      = 1'b0;
    w_op_we      = 1'b0;
    w_reg_we     = 1'b0;
    w_reg_wdata  = w_rd_val;
    w_req        = 1'b0;
    w_we         = 1'b0;
    w_addr       = r_pc;
    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (mem.ready) begin
          w_ir_we      = 1'b1;
          w_pc_next    = w_pc_inc;
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next_state = S_FETCH;
        case (w_opcode)
          OP_ADD: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = w_rd_val + w_rs_val;
          end
          OP_SUB: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = w_rd_val - w_rs_val;
          end
          OP_RST:  w_pc_next    = RESET_PC;
          OP_HALT: w_next_state = S_HALTED;
          OP_LOAD, OP_STORE, OP_LDI, OP_JMP, OP_BEQZ: w_next_state = S_OPER;
          default: ;
        endcase
      end
      S_OPER: begin
        w_req = 1'b1;
        if (mem.ready) begin
          w_op_we      = 1'b1;
          w_pc_next    = w_pc_inc;
          w_next_state = S_FETCH;
          case (w_opcode)
            OP_LDI: begin
              w_reg_we    = 1'b1;
              w_reg_wdata = mem.rdata;
            end
            OP_JMP: w_pc_next = mem.rdata[ADDR_W-1:0];
            OP_BEQZ: if (w_rd_val == '0) w_pc_next = mem.rdata[ADDR_W-1:0];
            OP_LOAD, OP_STORE: w_next_state = S_MEM;
            default: ;
          endcase
        end
      end
      S_MEM: begin
        w_req  = 1'b1;
        w_we   = (w_opcode == OP_STORE);
        w_addr = r_op;
        if (mem.ready) begin
          w_next_state = S_FETCH;
          if (w_opcode == OP_LOAD) begin
            w_reg_we    = 1'b1;
            w_reg_wdata = mem.rdata;
          end
        end
      end
      S_HALTED: ;
      default: w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
      r_ir <= '0;
      r_op <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_ir_we) r_ir <= mem.rdata;
      if (w_op_we) r_op <= mem.rdata[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_reg_we) begin
      r_regs[w_rd] <= w_reg_wdata;
    end
  end

  // Reset resets the state to FETCH asynchronously, so req/we must also be
  // masked by rst directly to stay low for the whole reset pulse.
  assign mem.req   = w_req & ~rst;
  assign mem.we    = w_we & ~rst;
  assign mem.addr  = w_addr;
  assign mem.wdata = w_rd_val;
  assign o_halted  = (r_state == S_HALTED);
  assign o_dbg_pc  = r_pc;

endmodule
